uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk_i cycles within one serial bit and flags the last one.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // clear_i holds the count at zero so the first bit after a handshake is full length.
  always_ff @(posedge clk_i) begin
    if (!reset_ni || clear_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_W bits LSB-first, optional parity, STOP_BITS stop bits.
// Parity bit is compiled in only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_out_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IDX_W = $clog2(DATA_W);

  // Elaboration-time guard on the legal parameter ranges.
  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_serializer: illegal parameter value");
  end

  uart_tx_state_t    state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              tick;

`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  assign busy_o = ~ready_o;

  // NOTE: every register here is assigned with <= so all state advances together
  // on the edge; blocking assignments would let later lines see half-updated values.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      // NOTE: the shift register is cleared too, so no stale payload survives an abort.
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      ready_o      <= 1'b1;
      serial_out_o <= UART_IDLE_LVL;
      done_o       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready_o is high throughout IDLE, so valid_i alone completes the handshake.
          if (valid_i) begin
            shift_q      <= data_i;
            bit_idx_q    <= '0;
            ready_o      <= 1'b0;
            serial_out_o <= UART_START_LVL;
            state_q      <= START;
`ifdef UART_TX_PARITY_EN
            parity_q     <= (^data_i) ^ (PARITY_ODD != 0);
`endif
          end
        end

        START: begin
          if (tick) begin
            serial_out_o <= shift_q[0];
            shift_q      <= shift_q >> 1;
            state_q      <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
              bit_idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
              serial_out_o <= parity_q;
              state_q      <= PARITY;
`else
              serial_out_o <= UART_IDLE_LVL;
              state_q      <= STOP;
`endif
            end else begin
              serial_out_o <= shift_q[0];
              shift_q      <= shift_q >> 1;
              bit_idx_q    <= bit_idx_q + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            serial_out_o <= UART_IDLE_LVL;
            state_q      <= STOP;
          end
        end
`endif

        STOP: begin
          // bit_idx_q is reused to count stop bits.
          if (tick) begin
            if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
              bit_idx_q <= '0;
              ready_o   <= 1'b1;
              done_o    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end

        default: begin
          bit_idx_q    <= '0;
          ready_o      <= 1'b1;
          serial_out_o <= UART_IDLE_LVL;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: lane 0 uses STOP_BITS=1/even parity, lane 1 STOP_BITS=2/odd parity.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] bits;
    int          len;
    int          abort_at;
    bit          b2b;
    logic [7:0]  data;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data  [2];
  logic       valid [2];
  logic       ready [2];
  logic       line  [2];
  logic       busy  [2];
  logic       done  [2];

  frame_t exp_q [2][$];
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .serial_out_o(line[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .serial_out_o(line[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle line image of one frame: bit c is the level during cycle c after the handshake edge.
  function automatic frame_t make_frame(input logic [7:0] d, input int stop_bits, input bit odd,
                                        input int abort_at, input bit b2b);
    frame_t      f;
    logic [15:0] lb;
    int          nb;
    lb    = '1;
    lb[0] = 1'b0;
    for (int i = 0; i < 8; i++) lb[1+i] = d[i];
    nb = 9;
    if (PAR_EN) begin
      lb[9] = (^d) ^ odd;
      nb    = 10;
    end
    nb         = nb + stop_bits;
    f.len      = nb * CPB;
    f.bits     = '0;
    for (int c = 0; c < f.len; c++) f.bits[c] = lb[c / CPB];
    f.abort_at = abort_at;
    f.b2b      = b2b;
    f.data     = d;
    return f;
  endfunction

  task automatic monitor(input int lane);
    frame_t      f;
    logic [63:0] cap;
    logic [63:0] mask;
    int          lim;
    int          gap;
    bit          bad;
    gap = 1000;
    forever begin
      @(negedge clk);
      gap++;
      if (done[lane] === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done lane %0d: got done=1, expected 0", lane);
      end
      if (line[lane] === 1'b0) begin
        if (exp_q[lane].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame lane %0d: got start bit, expected idle line", lane);
        end else begin
          f = exp_q[lane].pop_front();
          // A back-to-back start is seen on the first sample after the done cycle.
          if (f.b2b) check($sformatf("b2b_gap_%0d_%02h", lane, f.data), 64'(gap), 64'd1);
          cap    = '0;
          bad    = (ready[lane] !== 1'b0) || (busy[lane] !== 1'b1) || (done[lane] !== 1'b0);
          lim    = (f.abort_at >= 0) ? f.abort_at + 1 : f.len;
          for (int c = 1; c < lim; c++) begin
            @(negedge clk);
            cap[c] = line[lane];
            bad = bad || (ready[lane] !== 1'b0) || (busy[lane] !== 1'b1) || (done[lane] !== 1'b0);
          end
          mask = (64'd1 << lim) - 64'd1;
          check($sformatf("frame_line_%0d_%02h", lane, f.data), cap & mask, f.bits & mask);
          check($sformatf("busy_flags_%0d_%02h", lane, f.data), 64'(bad), 64'd0);
          @(negedge clk);
          if (f.abort_at >= 0)
            check($sformatf("abort_idle_%0d_%02h", lane, f.data),
                  64'({line[lane], ready[lane], done[lane]}), 64'b110);
          else
            check($sformatf("done_pulse_%0d_%02h", lane, f.data),
                  64'({line[lane], ready[lane], done[lane]}), 64'b111);
          gap = 0;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_ready(input int lane, input string what);
    int t = 0;
    while (ready[lane] !== 1'b1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (ready[lane] !== 1'b1) check($sformatf("timeout_%s_%0d", what, lane), 64'(ready[lane]), 64'd1);
  endtask

  task automatic send(input int lane, input logic [7:0] d, input int abort_at);
    wait_ready(lane, "send");
    exp_q[lane].push_back(make_frame(d, lane + 1, lane == 1, abort_at, 1'b0));
    valid[lane] = 1'b1;
    data[lane]  = d;
    @(posedge clk);
    #1;
    valid[lane] = 1'b0;
    data[lane]  = 8'h66;
  endtask

  task automatic wait_idle(input int lane);
    int t = 0;
    while (!(exp_q[lane].size() == 0 && ready[lane] === 1'b1) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) check($sformatf("timeout_idle_%0d", lane), 64'(exp_q[lane].size()), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid[0] = 1'b0; valid[1] = 1'b0;
    data[0]  = 8'h00; data[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line",  64'(line[0]),  64'd1);
    check("rst_ready", 64'(ready[0]), 64'd1);
    check("rst_busy",  64'(busy[0]),  64'd0);
    check("rst_done",  64'(done[0]),  64'd0);
    check("rst_ready_lane1", 64'(ready[1]), 64'd1);

    // Reset wins over a simultaneous handshake.
    valid[0] = 1'b1;
    data[0]  = 8'h12;
    @(posedge clk);
    #1;
    check("rst_priority_line",  64'(line[0]),  64'd1);
    check("rst_priority_ready", 64'(ready[0]), 64'd1);
    valid[0] = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    send(0, 8'hA5, -1); wait_idle(0);
    send(0, 8'h00, -1); wait_idle(0);
    send(0, 8'hFF, -1); wait_idle(0);
    send(0, 8'h01, -1); wait_idle(0);

    // valid_i held high across two frames; data_i wiggles while busy.
    exp_q[0].push_back(make_frame(8'h3C, 1, 1'b0, -1, 1'b0));
    exp_q[0].push_back(make_frame(8'hC3, 1, 1'b0, -1, 1'b1));
    valid[0] = 1'b1;
    data[0]  = 8'h3C;
    @(posedge clk);
    #1;
    data[0] = 8'hC3;
    repeat (10) @(posedge clk);
    #1;
    data[0] = 8'h55;
    repeat (10) @(posedge clk);
    #1;
    data[0] = 8'hC3;
    wait_ready(0, "b2b");
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    wait_idle(0);

    // Reset asserted during cycle 12 of a 0xFF frame.
    send(0, 8'hFF, 12);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle(0);
    send(0, 8'h81, -1); wait_idle(0);

    send(1, 8'h00, -1); wait_idle(1);
    send(1, 8'h5A, -1); wait_idle(1);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drain_0", 64'(exp_q[0].size()), 64'd0);
    check("queue_drain_1", 64'(exp_q[1].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
